// File: rtl/uart_pkg.sv
// Shared UART types and constants, used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam logic UART_IDLE_LVL        = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// STAGES-deep flip-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver with a one-byte valid/ready holding register and sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY_ODD parameter and parity_err_o.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_o,
`endif
  input  logic                 err_clr_i,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 rx_s_p1;
  logic                 expire;
  logic                 deliver;
  logic                 frame_set;
  logic                 ovr_set;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (UART_IDLE_LVL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (rx),
    .q     (rx_s)
  );

  assign expire    = (cnt == '0);
  assign deliver   = (state == STOP) && expire && rx_s;
  assign frame_set = (state == STOP) && expire && !rx_s;
  assign ovr_set   = deliver && valid_o && !ready_i;
  assign busy_o    = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_set;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != PARITY_ODD;
  endfunction

  assign par_set = (state == PARITY) && expire && parity_bad(shift, rx_s);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) parity_err_o <= 1'b0;
    else        parity_err_o <= par_set | (parity_err_o & ~err_clr_i);
  end
`endif

  // Data-only shift register: LSB arrives first, so each sample enters at the MSB.
  always_ff @(posedge clk_i) begin
    if (state == DATA && expire) shift <= {rx_s, shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      rx_s_p1     <= UART_IDLE_LVL;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_s_p1     <= rx_s;
      frame_err_o <= frame_set | (frame_err_o & ~err_clr_i);
      overrun_o   <= ovr_set | (overrun_o & ~err_clr_i);

      // A new byte always lands in the holding register, even over an unread one.
      if (deliver) begin
        data_o  <= shift;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s_p1 && !rx_s) begin
            cnt   <= HALF_CNT;
            state <= START;
          end
        end
        START: begin
          if (!expire) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            cnt     <= FULL_CNT;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!expire) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= FULL_CNT;
            if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!expire) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= FULL_CNT;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (!expire) cnt <= cnt - 1'b1;
          else         state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; build with UART_RX_PARITY_EN to cover parity.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx = 1'b1;
  logic       ready_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
  logic       par_flip = 1'b0;
`endif

  int         checks = 0;
  int         passed = 0;
  int         fails  = 0;
  int         vcnt;
  logic [7:0] cap;
  logic       saw_busy;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .rx           (rx),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o (parity_err_o),
`endif
    .err_clr_i    (err_clr_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clr();
    vcnt     = 0;
    cap      = 8'h00;
    saw_busy = 1'b0;
  endtask

  // One clock: sample outputs on the falling edge, then drive the next line level.
  task automatic tick(input logic b);
    @(negedge clk);
    if (valid_o) begin
      vcnt++;
      cap = data_o;
    end
    if (busy_o) saw_busy = 1'b1;
    rx = b;
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) tick(b);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, CPB);
`endif
    hold(stop, CPB);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_frame", frame_err_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    hold(1'b1, 20);

    // Clean frame with the consumer always ready
    ready_i = 1'b1;
    mon_clr();
    send(8'hA5, 1'b1);
    hold(1'b1, 20);
    check("a5_vcnt", vcnt, 1);
    check("a5_data", cap, 8'hA5);
    check("a5_frame", frame_err_o, 1'b0);
    check("a5_ovr", overrun_o, 1'b0);
    check("a5_busy", busy_o, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("a5_par", parity_err_o, 1'b0);
`endif

    // Back-to-back frames with nobody reading
    ready_i = 1'b0;
    send(8'h3C, 1'b1);
    check("b2b_data1", data_o, 8'h3C);
    check("b2b_valid1", valid_o, 1'b1);
    check("b2b_ovr1", overrun_o, 1'b0);
    send(8'hC3, 1'b1);
    hold(1'b1, 20);
    check("b2b_data2", data_o, 8'hC3);
    check("b2b_valid2", valid_o, 1'b1);
    check("b2b_ovr2", overrun_o, 1'b1);
    check("b2b_frame", frame_err_o, 1'b0);
    clr_pulse();
    check("ovr_clr", overrun_o, 1'b0);
    check("ovr_clr_valid", valid_o, 1'b1);
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("handshake_valid", valid_o, 1'b0);

    // Stop bit low
    ready_i = 1'b1;
    mon_clr();
    send(8'h55, 1'b0);
    hold(1'b1, 20);
    check("fe_vcnt", vcnt, 0);
    check("fe_flag", frame_err_o, 1'b1);
    check("fe_busy_seen", saw_busy, 1'b1);
    check("fe_busy", busy_o, 1'b0);
    clr_pulse();
    check("fe_clr", frame_err_o, 1'b0);

    // Short low glitch
    mon_clr();
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("gl_busy_seen", saw_busy, 1'b1);
    check("gl_vcnt", vcnt, 0);
    check("gl_frame", frame_err_o, 1'b0);
    check("gl_ovr", overrun_o, 1'b0);
    check("gl_busy", busy_o, 1'b0);

    // Holding register stable across a discarded frame
    ready_i = 1'b0;
    send(8'h81, 1'b1);
    hold(1'b1, 20);
    check("hold_data", data_o, 8'h81);
    check("hold_valid", valid_o, 1'b1);
    send(8'h55, 1'b0);
    hold(1'b1, 20);
    check("hold_frame", frame_err_o, 1'b1);
    check("hold_data2", data_o, 8'h81);
    check("hold_ovr", overrun_o, 1'b0);

    // Reset in the middle of a frame (0x66: start, 0, 1, 1 ...)
    hold(1'b0, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    check("mid_busy", busy_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    check("mid_data", data_o, 8'h00);
    check("mid_valid", valid_o, 1'b0);
    check("mid_frame", frame_err_o, 1'b0);
    check("mid_ovr", overrun_o, 1'b0);
    check("mid_busy0", busy_o, 1'b0);
    repeat (2) @(negedge clk);
    rx    = 1'b1;
    rst_i = 1'b1;
    mon_clr();
    hold(1'b1, 40);
    check("mid_no_deliver", vcnt, 0);
    check("mid_no_busy", saw_busy, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 0x07 with a wrong even-parity bit
    ready_i  = 1'b0;
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    par_flip = 1'b0;
    hold(1'b1, 20);
    check("par_data", data_o, 8'h07);
    check("par_valid", valid_o, 1'b1);
    check("par_err", parity_err_o, 1'b1);
    check("par_frame", frame_err_o, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
